// File: rtl/joy_db15_target.sv
// -----------------------------------------------------------------------------
// joy_db15_target
//
// Target (shift-register) end of the DB15 serial joystick link. The host
// reader drives joy_load / joy_clk; this block behaves like a chain of
// 74HC165s holding {joystick1, joystick2} and returns the bits on joy_data.
// All logic runs on clk. Both host lines are asynchronous to clk and are
// synchronised before use.
//
// Build option:
//   JOY_DB15_TARGET_DEGLITCH_EN - when defined, adds a run-length filter
//   behind each synchroniser so that single-cycle pulses on joy_clk or
//   joy_load are rejected. Latency grows by DEGLITCH-1 clk cycles.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   joy_clk      host shift clock (async), data advances on rising edge
//   joy_load     host load strobe (async), active-low transparent load
//   joystick1    player 1 buttons, active-high
//   joystick2    player 2 buttons, active-high
//   joy_data     serial data to host, active-low (pressed = 0)
//   frame_done   one-cycle pulse when the last frame bit has been shifted out
//   bit_cnt      shifts completed in the current frame, saturates at FRAME_BITS
//   link_active  high while the host keeps issuing load strobes
// -----------------------------------------------------------------------------
module joy_db15_target #(
    parameter int FRAME_BITS     = 32,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int DEGLITCH       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_clk,
    input  logic        joy_load,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        joy_data,
    output logic        frame_done,
    output logic [5:0]  bit_cnt,
    output logic        link_active
);

`ifdef JOY_DB15_TARGET_DEGLITCH_EN
    localparam bit DEGLITCH_EN = 1'b1;
`else
    localparam bit DEGLITCH_EN = 1'b0;
`endif

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DG_W = (DEGLITCH > 2) ? $clog2(DEGLITCH - 1) : 1;

    // ------------------------------------------------------------------
    // Two-flop synchronisers. Lines idle high, so reset to 1 to avoid a
    // spurious edge right after reset release.
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] load_sync_q;

    // NOTE: every clocked process uses non-blocking assignments so all
    // flops sample the pre-edge value of their neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            load_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], joy_clk};
            load_sync_q <= {load_sync_q[0], joy_load};
        end
    end

    // Bit 0 = joy_clk, bit 1 = joy_load.
    logic [1:0] sync_lines;
    logic [1:0] filt_lines;

    assign sync_lines = {load_sync_q[1], clk_sync_q[1]};

    // ------------------------------------------------------------------
    // Optional run-length filter. The synchroniser output register holds
    // the first sample of a new level; the filtered value follows once
    // DEGLITCH consecutive samples agree.
    // ------------------------------------------------------------------
    if (DEGLITCH_EN && (DEGLITCH > 1)) begin : g_deglitch
        for (genvar i = 0; i < 2; i++) begin : g_line
            logic [DG_W-1:0] run_q;
            logic            filt_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    run_q  <= '0;
                    filt_q <= 1'b1;
                end else if (sync_lines[i] == filt_q) begin
                    run_q <= '0;
                end else if (run_q == DG_W'(DEGLITCH - 2)) begin
                    run_q  <= '0;
                    filt_q <= sync_lines[i];
                end else begin
                    run_q <= run_q + DG_W'(1);
                end
            end

            assign filt_lines[i] = filt_q;
        end
    end else begin : g_bypass
        assign filt_lines = sync_lines;
    end

    // ------------------------------------------------------------------
    // Edge detection against a third register.
    // ------------------------------------------------------------------
    logic clk_prev_q;
    logic load_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_prev_q  <= 1'b1;
            load_prev_q <= 1'b1;
        end else begin
            clk_prev_q  <= filt_lines[0];
            load_prev_q <= filt_lines[1];
        end
    end

    logic clk_rise;
    logic load_rise;
    logic load_fall;
    logic do_load;
    logic do_shift;

    assign clk_rise  =  filt_lines[0] & ~clk_prev_q;
    assign load_rise =  filt_lines[1] & ~load_prev_q;
    assign load_fall = ~filt_lines[1] &  load_prev_q;

    // The cycle in which load is seen rising still counts as a load cycle,
    // so a coincident joy_clk edge is swallowed rather than shifting.
    assign do_load  = ~filt_lines[1] | load_rise;
    assign do_shift = clk_rise & ~do_load;

    // ------------------------------------------------------------------
    // Shift register, bit counter and frame pulse.
    // ------------------------------------------------------------------
    logic [31:0]           joy_word;
    logic [FRAME_BITS-1:0] load_value;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;
    logic [5:0]            bit_cnt_q;
    logic                  frame_done_q;

    // Short frames drop bits from the joystick2 LSB end.
    assign joy_word   = {joystick1, joystick2};
    assign load_value = ~joy_word[31 -: FRAME_BITS];

    // NOTE: shift_d gets its hold value first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        shift_d = shift_q;
        if (do_load) begin
            shift_d = load_value;
        end else if (do_shift) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q      <= '1;
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            frame_done_q <= do_shift && (bit_cnt_q == 6'(FRAME_BITS - 1));
            if (do_load) begin
                bit_cnt_q <= '0;
            end else if (do_shift && (bit_cnt_q != 6'(FRAME_BITS))) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Link timeout: restarted by every load strobe, holds once expired.
    // ------------------------------------------------------------------
    logic [TO_W-1:0] to_cnt_q;
    logic            link_active_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q      <= '0;
            link_active_q <= 1'b0;
        end else if (load_fall) begin
            to_cnt_q      <= '0;
            link_active_q <= 1'b1;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                link_active_q <= 1'b0;
            end
        end
    end

    assign joy_data    = shift_q[FRAME_BITS-1];
    assign frame_done  = frame_done_q;
    assign bit_cnt     = bit_cnt_q;
    assign link_active = link_active_q;

endmodule

// File: tb/tb_joy_db15_target.sv
// -----------------------------------------------------------------------------
// tb_joy_db15_target
//
// Host-side exerciser for joy_db15_target: drives joy_load / joy_clk like the
// DB15 reader and checks the returned serial stream against a frame model.
// Expected joy_data bits are queued as each host clock edge is issued and
// popped when the line is sampled.
// -----------------------------------------------------------------------------
module tb_joy_db15_target;

    localparam int TIMEOUT = 100;
    localparam int HALF    = 8;
`ifdef JOY_DB15_TARGET_DEGLITCH_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        reset;
    logic        joy_clk;
    logic        joy_load;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        joy_data;
    logic        frame_done;
    logic [5:0]  bit_cnt;
    logic        link_active;

    joy_db15_target #(
        .FRAME_BITS     (32),
        .TIMEOUT_CYCLES (TIMEOUT),
        .DEGLITCH       (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .joy_clk     (joy_clk),
        .joy_load    (joy_load),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .joy_data    (joy_data),
        .frame_done  (frame_done),
        .bit_cnt     (bit_cnt),
        .link_active (link_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   fd_cnt      = 0;
    logic exp_q[$];

    // Counts high samples, so a stretched pulse counts more than once.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Host view of a frame: bit i seen after i shifts, ones once exhausted.
    function automatic logic exp_bit(input logic [31:0] frame, input int i);
        if (i < 32) return ~frame[31-i];
        return 1'b1;
    endfunction

    task automatic pulse_clk();
        @(posedge clk); #1 joy_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 joy_clk = 1'b0;
        repeat (HALF - 1) @(posedge clk);
    endtask

    task automatic do_load();
        @(posedge clk); #1 joy_load = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 joy_load = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic shift_run(input logic [31:0] frame, input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            @(negedge clk);
            check($sformatf("joy_data[%0d]", k), joy_data, exp_q.pop_front());
            pulse_clk();
            exp_q.push_back(exp_bit(frame, k + 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (limit %0t)", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] frame;
        int          fd_base;
        int          n;

        reset     = 1'b1;
        joy_clk   = 1'b0;
        joy_load  = 1'b1;
        joystick1 = 16'h8001;
        joystick2 = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_joy_data",    joy_data,    1);
        check("rst_bit_cnt",     bit_cnt,     0);
        check("rst_link_active", link_active, 0);
        check("rst_frame_done",  fd_cnt,      0);

        // Full frame followed by 8 overlong shifts.
        joystick1 = 16'h8001;
        joystick2 = 16'hFFFF;
        frame     = {joystick1, joystick2};
        do_load();
        check("link_after_load", link_active, 1);
        exp_q.delete();
        exp_q.push_back(exp_bit(frame, 0));
        fd_base = fd_cnt;
        shift_run(frame, 0, 32);
        check("frame1_done_cnt", fd_cnt - fd_base, 1);
        check("frame1_bit_cnt",  bit_cnt, 32);
        shift_run(frame, 32, 8);
        @(negedge clk);
        check("overlong_data",     joy_data, exp_q.pop_front());
        check("overlong_bit_cnt",  bit_cnt, 32);
        check("overlong_done_cnt", fd_cnt - fd_base, 1);

        // Abort after 10 shifts, then a full frame with inputs moving mid-frame.
        joystick1 = 16'hA5C3;
        joystick2 = 16'h3C5A;
        frame     = {joystick1, joystick2};
        do_load();
        exp_q.delete();
        exp_q.push_back(exp_bit(frame, 0));
        fd_base = fd_cnt;
        shift_run(frame, 0, 10);
        check("abort_pre_cnt", bit_cnt, 10);
        @(posedge clk); #1 joy_load = 1'b0;
        repeat (HALF) @(negedge clk);
        check("abort_bit_cnt", bit_cnt, 0);
        check("abort_msb",     joy_data, exp_bit(frame, 0));
        check("abort_no_done", fd_cnt - fd_base, 0);
        @(posedge clk); #1 joy_load = 1'b1;
        repeat (HALF) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(exp_bit(frame, 0));
        shift_run(frame, 0, 5);
        joystick1 = 16'h0000;
        joystick2 = 16'hFFFF;
        shift_run(frame, 5, 27);
        @(negedge clk);
        check("refill_tail",     joy_data, exp_q.pop_front());
        check("refill_done_cnt", fd_cnt - fd_base, 1);

        // Load release and clock rise arriving together: load wins.
        joystick1 = 16'h8001;
        joystick2 = 16'h0000;
        frame     = {joystick1, joystick2};
        @(posedge clk); #1 joy_load = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 joy_load = 1'b1;
        joy_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 joy_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(exp_bit(frame, 0));
        check("coincide_data",    joy_data, exp_q.pop_front());
        check("coincide_bit_cnt", bit_cnt, 0);

        // One-cycle glitch on joy_clk.
        @(posedge clk); #1 joy_clk = 1'b1;
        @(posedge clk); #1 joy_clk = 1'b0;
        repeat (10) @(negedge clk);
`ifdef JOY_DB15_TARGET_DEGLITCH_EN
        exp_q.push_back(exp_bit(frame, 0));
        check("glitch_bit_cnt", bit_cnt, 0);
`else
        exp_q.push_back(exp_bit(frame, 1));
        check("glitch_bit_cnt", bit_cnt, 1);
`endif
        check("glitch_data", joy_data, exp_q.pop_front());

        // Link timeout.
        n = 0;
        while (link_active !== 1'b0 && n < 3 * TIMEOUT) begin
            @(posedge clk); #1 n++;
        end
        check("link_idle", link_active, 0);
        @(posedge clk); #1 joy_load = 1'b0;
        n = 0;
        while (link_active !== 1'b1 && n < 20) begin
            @(posedge clk); #1 n++;
        end
        check("link_rise_latency", n, LAT);
        n = 0;
        while (link_active === 1'b1 && n < 3 * TIMEOUT) begin
            @(posedge clk); #1 n++;
            if (n == HALF) joy_load = 1'b1;
        end
        check("link_timeout_cycles", n, TIMEOUT);
        repeat (20) @(negedge clk);
        check("link_hold_low", link_active, 0);

        // Reset in the middle of a frame.
        joystick1 = 16'hA5C3;
        joystick2 = 16'h3C5A;
        frame     = {joystick1, joystick2};
        do_load();
        exp_q.delete();
        exp_q.push_back(exp_bit(frame, 0));
        shift_run(frame, 0, 4);
        check("pre_reset_cnt",  bit_cnt, 4);
        check("pre_reset_link", link_active, 1);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        check("midrst_data",       joy_data,    1);
        check("midrst_bit_cnt",    bit_cnt,     0);
        check("midrst_frame_done", frame_done,  0);
        check("midrst_link",       link_active, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        check("postrst_data",    joy_data, 1);
        check("postrst_bit_cnt", bit_cnt,  0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/joy_db15_target.md
Name: joy_db15_target

Overview:
- Target-side emulation of the DB15 serial joystick adapter: the shift-register end of the JOY_LOAD/JOY_CLK/JOY_DATA link.
- Takes two parallel 16-bit joystick words from core logic and serialises them onto the data line when the host reader drives load and clock.
- Sits behind the open-drain user port. Used to drive a second MiSTer acting as an adapter, and as a loop-back bench partner for the existing DB15 reader.

Parameters:
- FRAME_BITS, 32: bits per frame; frame = {joystick1, joystick2}, joystick1 bit 15 first; values below 32 truncate from the joystick2 LSB end.
- TIMEOUT_CYCLES, 5000000: clk cycles with no load falling edge before link_active drops (100 ms at 50 MHz).
- DEGLITCH, 3: consecutive equal samples required by the optional input filter.

Ports:
- clk, input, 1: system clock; all logic rises on it.
- reset, input, 1: asynchronous, active-high reset.
- joy_clk, input, 1: host shift clock; asynchronous; data advances on its rising edge.
- joy_load, input, 1: host load strobe; asynchronous; active-low parallel load.
- joystick1, input, 16: player 1 buttons, active-high, sampled on clk.
- joystick2, input, 16: player 2 buttons, active-high, sampled on clk.
- joy_data, output, 1: serial data to host, active-low (pressed = 0).
- frame_done, output, 1: one-cycle pulse when bit FRAME_BITS-1 has been shifted out.
- bit_cnt, output, 6: shifts completed in the current frame; saturates at FRAME_BITS.
- link_active, output, 1: high while the host is polling.

Behaviour:
- Reset (async assert, sync release) sets:
  - shift register to all ones, so joy_data = 1;
  - bit_cnt = 0, frame_done = 0, link_active = 0;
  - timeout counter = 0;
  - synchroniser stages to 1 (idle-high lines).
- Input synchronisation:
  - joy_clk and joy_load each pass through a 2-FF synchroniser.
  - Edge detect compares the synchronised value with a third register.
- LOAD state (synchronised joy_load = 0):
  - The shift register reloads every cycle with ~{joystick1, joystick2}[31 -: FRAME_BITS] (transparent load, 74HC165-like).
  - bit_cnt = 0.
  - joy_clk edges are ignored.
- SHIFT state (synchronised joy_load = 1), on each detected joy_clk rising edge:
  - shift left, with 1 inserted at the LSB (serial input tied high);
  - bit_cnt increments, saturating at FRAME_BITS;
  - on the edge where bit_cnt goes FRAME_BITS-1 -> FRAME_BITS, frame_done pulses for exactly 1 cycle.
- joy_data is driven registered from the shift register MSB.
- Latency: joy_data updates 3 clk cycles after a joy_clk or joy_load pin transition (2 sync + 1 register).
  - Host clock half-period must be at least 4 clk cycles (6 with the optional filter).
- Boundary conditions:
  - Overlong frame: after FRAME_BITS shifts joy_data stays 1, bit_cnt holds at FRAME_BITS, and no further frame_done pulses occur.
  - Load falls mid-frame: the frame is aborted and the register reloads; frame_done does not pulse for the aborted frame.
  - Load rise and clk rise detected in the same cycle: load wins; no shift occurs in that cycle.
  - Joystick inputs changing during SHIFT have no effect until the next load.
- Link timeout:
  - Each synchronised joy_load falling edge clears the counter and sets link_active = 1.
  - Otherwise the counter increments; when it reaches TIMEOUT_CYCLES, link_active = 0 and the counter holds.
- Reset mid-frame returns every output to its reset value immediately.

Optional Feature:
- Macro: JOY_DB15_TARGET_DEGLITCH_EN.
- When defined: after the synchroniser, each line changes its filtered value only after DEGLITCH consecutive equal samples. Latency rises to 3 + DEGLITCH - 1 cycles. Single-cycle pulses on joy_clk or joy_load are rejected.
- When undefined: the synchroniser output is used directly and the filter logic is absent.

Test Plan:
- Reset release with joystick1 = 16'h8001, joystick2 = 16'h0000 and no host activity -> joy_data = 1, bit_cnt = 0, link_active = 0.
- Load low then high, then 32 clk pulses (half-period 8 cycles), joystick1 = 16'h8001, joystick2 = 16'hFFFF -> joy_data sequence is 0,1×14,0, then 0×16; frame_done pulses once after the 32nd edge; link_active = 1.
- Same frame followed by 8 extra clk pulses -> joy_data = 1 for all 8; bit_cnt stays 32; no second frame_done.
- Load pulled low after 10 shifts -> bit_cnt = 0, MSB reloaded, no frame_done; a following full frame delivers correct data.
- No load edge for TIMEOUT_CYCLES (set to 100 for the bench) -> link_active falls on cycle 100 after the last load fall; the next load fall sets it within 3 cycles.
- JOY_DB15_TARGET_DEGLITCH_EN defined, 1-cycle glitch on joy_clk during SHIFT -> no shift, bit_cnt unchanged; the same test without the macro -> joy_data advances one bit.
